// File: rtl/bvh_node_packer_pkg.sv
// Shared types for the BVH node packer: node/AABB/fixed-point structs, raw layout sizes, FSM states.
// Used by bvh_node_packer and bvh_node_raw_pack (optional BVH_PACK_OFFSET_EN affects those modules).
package bvh_node_packer_pkg;

  localparam int BVH_NODE_RAW_WIDTH = 224;
  localparam int BVH_NODE_BEATS     = 7;
  localparam int BVH_BEAT_WIDTH     = 32;

  // Dim[0]=x, Dim[1]=y, Dim[2]=z
  typedef struct packed {
    logic [2:0][31:0] Dim;
  } Fixed3;

  typedef struct packed {
    Fixed3 Min;
    Fixed3 Max;
  } AABB;

  typedef struct packed {
    AABB              Aabb;
    logic [1:0][15:0] Nodes;
  } BVH_Node;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } pack_state_e;

endpackage

// File: rtl/bvh_node_raw_pack.sv
// Combinational BVH_Node -> 224-bit node_raw packer (Min.x in the MSBs, child links in the LSBs).
// With BVH_PACK_OFFSET_EN defined, an offset port exists and is subtracted from Min/Max (wrapping).
module bvh_node_raw_pack
  import bvh_node_packer_pkg::*;
(
  input  BVH_Node                        node,
`ifdef BVH_PACK_OFFSET_EN
  input  Fixed3                          offset,
`endif
  output logic [BVH_NODE_RAW_WIDTH-1:0]  raw
);

  logic [2:0][31:0] min_adj;
  logic [2:0][31:0] max_adj;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dim
`ifdef BVH_PACK_OFFSET_EN
      assign min_adj[gi] = node.Aabb.Min.Dim[gi] - offset.Dim[gi];
      assign max_adj[gi] = node.Aabb.Max.Dim[gi] - offset.Dim[gi];
`else
      assign min_adj[gi] = node.Aabb.Min.Dim[gi];
      assign max_adj[gi] = node.Aabb.Max.Dim[gi];
`endif
      // Min occupies [223:128], Max [127:32], x first within each
      assign raw[BVH_NODE_RAW_WIDTH-1-32*gi -: 32] = min_adj[gi];
      assign raw[127-32*gi -: 32]                  = max_adj[gi];
    end
  endgenerate

  assign raw[31:0] = {node.Nodes[0], node.Nodes[1]};

endmodule

// File: rtl/bvh_node_packer.sv
// Serializes one BVH_Node per handshake into seven 32-bit beats tagged with a node index.
// Optional BVH_PACK_OFFSET_EN adds an offset port whose value is subtracted from the AABB at accept.
module bvh_node_packer
  import bvh_node_packer_pkg::*;
#(
  parameter int NODE_INDEX_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  BVH_Node                     in_node,
`ifdef BVH_PACK_OFFSET_EN
  input  Fixed3                       offset,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 out_word,
  output logic [2:0]                  out_beat,
  output logic                        out_last,
  output logic [NODE_INDEX_WIDTH-1:0] out_node_index,
  output logic [NODE_INDEX_WIDTH-1:0] nodes_written
);

  localparam logic [2:0] LAST_BEAT = 3'(BVH_NODE_BEATS - 1);
  localparam logic [NODE_INDEX_WIDTH-1:0] IDX_ONE = {{(NODE_INDEX_WIDTH-1){1'b0}}, 1'b1};

  pack_state_e                   state_reg, state_next;
  logic [2:0]                    beat_reg, beat_next;
  logic                          run_reg;
  logic [BVH_NODE_RAW_WIDTH-1:0] raw_packed, raw_reg;
  logic [NODE_INDEX_WIDTH-1:0]   index_reg, written_reg;
  logic                          last_beat, accept, fire, node_done;

  bvh_node_raw_pack u_raw_pack (
    .node   (in_node),
`ifdef BVH_PACK_OFFSET_EN
    .offset (offset),
`endif
    .raw    (raw_packed)
  );

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    last_beat  = (beat_reg == LAST_BEAT);
    case (state_reg)
      ST_IDLE: in_ready = run_reg;
      ST_SEND: begin
        out_valid = 1'b1;
        // Next node may be taken while the final beat drains, giving no bubble
        in_ready  = run_reg && last_beat && out_ready;
      end
      default: ;
    endcase
    if (clear) in_ready = 1'b0;
    fire      = out_valid && out_ready;
    node_done = fire && last_beat;
    accept    = in_valid && in_ready;
    if (clear) begin
      state_next = ST_IDLE;
      beat_next  = 3'd0;
    end else if (accept) begin
      state_next = ST_SEND;
      beat_next  = 3'd0;
    end else if (fire) begin
      if (last_beat) begin
        state_next = ST_IDLE;
        beat_next  = 3'd0;
      end else begin
        beat_next = beat_reg + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= ST_IDLE;
      beat_reg    <= 3'd0;
      run_reg     <= 1'b0;
      raw_reg     <= '0;
      index_reg   <= '0;
      written_reg <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      run_reg   <= 1'b1;
      // The current beat always sits in the top word; shift after each delivered beat
      if (!clear && accept)
        raw_reg <= raw_packed;
      else if (!clear && fire)
        raw_reg <= raw_reg << BVH_BEAT_WIDTH;
      if (clear) begin
        index_reg   <= '0;
        written_reg <= '0;
      end else if (node_done) begin
        index_reg <= index_reg + IDX_ONE;
        if (written_reg != {NODE_INDEX_WIDTH{1'b1}})
          written_reg <= written_reg + IDX_ONE;
      end
    end
  end

  assign out_word       = raw_reg[BVH_NODE_RAW_WIDTH-1 -: BVH_BEAT_WIDTH];
  assign out_beat       = beat_reg;
  assign out_last       = out_valid && last_beat;
  assign out_node_index = index_reg;
  assign nodes_written  = written_reg;

endmodule

// File: tb/tb_bvh_node_packer.sv
// Scoreboard bench for bvh_node_packer: random nodes, reference beat model, directed clear/reset/offset cases.
module tb_bvh_node_packer;
  import bvh_node_packer_pkg::*;

`ifdef BVH_PACK_OFFSET_EN
  localparam bit OFFSET_EN = 1'b1;
`else
  localparam bit OFFSET_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  BVH_Node     in_node = '0;
  Fixed3       offset = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_word;
  logic [2:0]  out_beat;
  logic        out_last;
  logic [15:0] out_node_index;
  logic [15:0] nodes_written;

  int compared = 0;
  int mismatched = 0;
  logic [34:0] exp_q[$];
  int model_idx = 0;
  int model_written = 0;
  int fire_cnt = 0;
  int cyc = 0;
  int ready_mode = 0;
  bit stalled = 0;
  logic [34:0] prev_out;

  bvh_node_packer #(.NODE_INDEX_WIDTH(16)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .clear          (clear),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_node        (in_node),
`ifdef BVH_PACK_OFFSET_EN
    .offset         (offset),
`endif
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_word       (out_word),
    .out_beat       (out_beat),
    .out_last       (out_last),
    .out_node_index (out_node_index),
    .nodes_written  (nodes_written)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: seven beats in layout order, AABB minus offset when the feature is on
  function automatic void push_node(input BVH_Node n, input Fixed3 o);
    logic [31:0] w [7];
    for (int d = 0; d < 3; d++) begin
      w[d]     = n.Aabb.Min.Dim[d] - (OFFSET_EN ? o.Dim[d] : 32'd0);
      w[3 + d] = n.Aabb.Max.Dim[d] - (OFFSET_EN ? o.Dim[d] : 32'd0);
    end
    w[6] = {n.Nodes[0], n.Nodes[1]};
    for (int b = 0; b < 7; b++) exp_q.push_back({3'(b), w[b]});
  endfunction

  function automatic BVH_Node rand_node();
    BVH_Node n;
    for (int d = 0; d < 3; d++) begin
      n.Aabb.Min.Dim[d] = $urandom;
      n.Aabb.Max.Dim[d] = $urandom;
    end
    n.Nodes[0] = 16'($urandom);
    n.Nodes[1] = 16'($urandom);
    return n;
  endfunction

  // Monitor: pops expected beats and tracks completed-node count
  initial begin
    logic [34:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!resetn) begin
        exp_q.delete();
        model_idx = 0;
        model_written = 0;
        stalled = 0;
        continue;
      end
      check("nodes_written", 64'(nodes_written), 64'(model_written));
      if (out_valid && in_ready) check("in_ready_only_on_beat6", {out_beat, out_ready}, {3'd6, 1'b1});
      if (stalled && out_valid) check("stall_hold", {out_beat, out_word}, prev_out);
      if (out_valid && out_ready) begin
        fire_cnt++;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_beat: got beat %0d word %h expected none", out_beat, out_word);
        end else begin
          e = exp_q.pop_front();
          check("beat_word", {out_beat, out_word}, e);
          check("node_index", 64'(out_node_index), 64'(16'(model_idx)));
          check("out_last", 64'(out_last), 64'(e[34:32] == 3'd6));
          if (e[34:32] == 3'd6) begin
            model_idx++;
            if (model_written < 65535) model_written++;
          end
        end
      end
      stalled = out_valid && !out_ready;
      prev_out = {out_beat, out_word};
      if (clear) begin
        exp_q.delete();
        model_idx = 0;
        model_written = 0;
        stalled = 0;
      end
    end
  end

  // Sink readiness pattern
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = ~out_ready;
      endcase
    end
  end

  task automatic offer(input BVH_Node n);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_node = n;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        push_node(n, offset);
        ok = 1;
      end
      @(posedge clk);
      #1;
      if (ok) break;
    end
    in_valid = 1'b0;
    if (!ok) check("offer_timeout", 64'd1, 64'(ok));
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !out_valid) begin
        done = 1;
        break;
      end
    end
    if (!done) check("idle_timeout", 64'd1, 64'(done));
  endtask

  task automatic wait_beat(input logic [2:0] b);
    bit seen;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid && out_beat == b) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!seen) check("wait_beat_timeout", 64'd1, 64'(seen));
  endtask

  initial begin
    BVH_Node n;
    int f0, c0;
    // Reset values
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_word", 64'(out_word), 64'd0);
    check("rst_out_beat", 64'(out_beat), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_index", 64'(out_node_index), 64'd0);
    check("rst_written", 64'(nodes_written), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3 resetn = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 64'(in_ready), 64'd1);

    // Directed single node
    n = '0;
    n.Aabb.Min.Dim[0] = 32'd1; n.Aabb.Min.Dim[1] = 32'd2; n.Aabb.Min.Dim[2] = 32'd3;
    n.Aabb.Max.Dim[0] = 32'd4; n.Aabb.Max.Dim[1] = 32'd5; n.Aabb.Max.Dim[2] = 32'd6;
    n.Nodes[0] = 16'h0001; n.Nodes[1] = 16'h0002;
    offer(n);
    check("first_beat_latency", {out_valid, out_beat, out_word}, {1'b1, 3'd0, 32'd1});
    wait_idle();
    check("written_after_one", 64'(nodes_written), 64'd1);

    // Three nodes back-to-back, full throughput
    offer(rand_node());
    f0 = fire_cnt;
    c0 = cyc;
    offer(rand_node());
    offer(rand_node());
    for (int i = 0; i < 100 && cyc < c0 + 21; i++) @(posedge clk);
    #1;
    check("burst_21_beats", 64'(fire_cnt - f0), 64'd21);
    wait_idle();

    // Alternating and random backpressure
    ready_mode = 2;
    offer(rand_node());
    wait_idle();
    ready_mode = 1;
    for (int k = 0; k < 4; k++) offer(rand_node());
    wait_idle();
    ready_mode = 0;
    @(posedge clk);
    #1;

    // clear in IDLE, then clear mid-node at index 5
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clear_idle_written", 64'(nodes_written), 64'd0);
    for (int k = 0; k < 6; k++) offer(rand_node());
    wait_beat(3'd3);
    check("index_before_clear", 64'(out_node_index), 64'd5);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clear_drops_valid", 64'(out_valid), 64'd0);
    check("clear_written", 64'(nodes_written), 64'd0);
    offer(rand_node());
    check("index_after_clear", {out_beat, out_node_index}, {3'd0, 16'd0});
    wait_idle();

    // Offset subtraction with wrap (or verbatim packing)
    offset.Dim[0] = 32'h0001_0000; offset.Dim[1] = 32'h0; offset.Dim[2] = 32'hFFFF_FFFF;
    n = rand_node();
    n.Aabb.Min.Dim[0] = 32'h0001_8000;
    n.Aabb.Min.Dim[2] = 32'h0;
    offer(n);
    check("offset_beat0", 64'(out_word), OFFSET_EN ? 64'h0000_8000 : 64'h0001_8000);
    wait_idle();
    offset = '0;

    // Asynchronous reset mid beat 4
    offer(rand_node());
    wait_beat(3'd4);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd0);
    check("async_rst_index", 64'(out_node_index), 64'd0);
    #10 resetn = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_async_rst", 64'(in_ready), 64'd1);
    offer(rand_node());
    check("index_after_rst", 64'(out_node_index), 64'd0);
    wait_idle();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    compared++;
    mismatched++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bvh_node_packer.md
Name: bvh_node_packer

Overview:
- Inverse of the BVH node decode path: accepts one decoded BVH_Node (AABB plus two 16-bit child links) per handshake.
- Packs the node into the 224-bit node_raw layout and streams it as seven 32-bit beats to the node-memory writer / host upload bus.
- Tags each beat with an auto-incrementing node index, so BVH content can be rebuilt or uploaded at runtime instead of being loaded from a static memory file.

Parameters:
NODE_INDEX_WIDTH, 16, width of the node index counter and of out_node_index; matches child link width.
BEATS, 7, beats per node (224/32); fixed, not overridable.

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
clear  input  1  sync pulse: abort current node, index counter := 0
in_valid  input  1  node offered
in_ready  output  1  node accepted when in_valid && in_ready
in_node  input  BVH_Node  Aabb.Min/Max (Fixed3) and Nodes[0..1]
offset  input  Fixed3  world offset to remove (present only with BVH_PACK_OFFSET_EN)
out_valid  output  1  beat valid
out_ready  input  1  sink accepts beat
out_word  output  32  beat payload
out_beat  output  3  beat number 0..6
out_last  output  1  high on beat 6
out_node_index  output  NODE_INDEX_WIDTH  index of node being sent
nodes_written  output  NODE_INDEX_WIDTH  completed node count since reset/clear

Behaviour:
- Reset is asynchronous and active-low, on the clk/resetn pair. Asserting resetn low immediately forces:
  - state IDLE, out_valid=0, out_word=0, out_beat=0, out_last=0
  - out_node_index=0, nodes_written=0
  - in_ready=0 while in reset; in_ready=1 in the first cycle after release
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SEND: out_valid=1, out_word/out_beat/out_last/out_node_index held stable until out_ready.
- Capture: on accept, register the 224-bit packed word (offset-adjusted if the feature is enabled) and enter SEND with beat=0. Accept-to-first-beat latency is 1 cycle.
- Beat order, matching the node_raw bit layout MSB-first:
  - 0 = Min.x [223:192]
  - 1 = Min.y [191:160]
  - 2 = Min.z [159:128]
  - 3 = Max.x [127:96]
  - 4 = Max.y [95:64]
  - 5 = Max.z [63:32]
  - 6 = {Nodes[0], Nodes[1]} [31:0]
- Beat advance: on out_valid && out_ready, beat increments.
- On completion of beat 6:
  - out_node_index increments and wraps modulo 2^NODE_INDEX_WIDTH.
  - nodes_written increments and saturates at all-ones.
- Back-to-back: in_ready = IDLE || (SEND && beat==6 && out_ready). This is a combinational path from out_ready; it is permitted.
  - If a new node is accepted in that cycle, go directly to SEND beat 0 with the new node; no bubble.
  - Otherwise return to IDLE.
- Stall: out_ready low holds all outputs unchanged indefinitely.
- Throughput: with out_ready constantly high, one node per 7 cycles.
- clear:
  - In IDLE: index and nodes_written := 0.
  - In SEND: the current node is dropped, state := IDLE, index and nodes_written := 0. Beats already delivered stay delivered; the sink discards partial nodes by watching out_beat.
  - clear wins over a simultaneous beat-6 completion and over a simultaneous input accept; in_ready is forced 0 while clear=1.
- out_word is registered; no combinational path from in_node to outputs.

Optional Feature:
- Macro: BVH_PACK_OFFSET_EN.
- Defined:
  - The offset port exists.
  - At capture, Min and Max are stored as value minus offset.Dim[i], per dimension, 32-bit two's complement with wrap, no saturation.
  - This is the exact inverse of the decode-side offset add.
  - offset is sampled only at accept.
- Undefined:
  - No offset port.
  - AABB fields are packed verbatim.

Decomposition:
- Shared package/Types:
  - BVH_Node, AABB, Fixed3 (existing)
  - BVH_NODE_RAW_WIDTH=224
  - BVH_NODE_BEATS=7
  - enum for the IDLE/SEND states
- Sub-module: bvh_node_raw_pack, a combinational BVH_Node (+ optional offset) to 224-bit pack function/module, reusable by a future host-side loader.
- Serializer, counters and FSM stay in the top module.

Test Plan:
- Single node, out_ready=1, Min=(1,2,3), Max=(4,5,6), Nodes=(0x0001,0x0002) -> beats 0x1,0x2,0x3,0x4,0x5,0x6,0x00010002 on consecutive cycles. out_last only on beat 6, out_node_index=0, then nodes_written=1.
- Three nodes offered continuously, out_ready=1 -> 21 consecutive valid beats with no gaps, node indices 0,1,2, in_ready high only in the beat-6 cycles after the first accept.
- out_ready toggling 1-0-1 pattern during a node -> each word held stable while stalled, no beat lost or duplicated, total 7 accepted beats.
- clear asserted at beat 3 of node index 5 -> out_valid=0 next cycle. Next node is sent with out_node_index=0 from beat 0, nodes_written=0.
- resetn pulsed low mid-beat 4 -> out_valid drops without waiting for clk. After release in_ready=1, index 0.
- With BVH_PACK_OFFSET_EN, offset=(0x10000,0,0xFFFFFFFF), Min.x=0x18000, Min.z=0 -> beat0=0x00008000, beat2=0x00000001 (wrap). Without the macro the same Min yields beat0=0x00018000.
